// File: rtl/silu_pwl_bwd_if.sv
// Stream bundle for silu_pwl_bwd: x/g pair in, dx out, valid/ready on both sides.
//   in_valid/in_ready/x/g    : input pair handshake and payload
//   out_valid/out_ready/dx   : result handshake and payload
// master = stream producer/consumer side (testbench), slave = the block.
interface silu_pwl_bwd_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] g;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dx;

  modport master (
    output in_valid, x, g, out_ready,
    input  in_ready, out_valid, dx
  );

  modport slave (
    input  in_valid, x, g, out_ready,
    output in_ready, out_valid, dx
  );
endinterface

// File: rtl/silu_pwl_bwd.sv
// Backward PWL SiLU: dx = sat(g * silu'(x) >>> FRAC), 3-stage pipeline.
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : x/g input stream and dx output stream (valid/ready)
//   sat_clr       : synchronous clear of sat_cnt (wins over increment)
//   sat_cnt       : saturating count of saturated output transfers
module silu_pwl_bwd #(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  silu_pwl_bwd_if.slave    bus,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int unsigned PW = 2 * W;

  // Segment lower bounds (Q8.8)
  localparam logic signed [W-1:0] X_M6  = W'(-1536);
  localparam logic signed [W-1:0] X_M4  = W'(-1024);
  localparam logic signed [W-1:0] X_M15 = W'(-384);
  localparam logic signed [W-1:0] X_M05 = W'(-128);
  localparam logic signed [W-1:0] X_P05 = W'(128);
  localparam logic signed [W-1:0] X_P15 = W'(384);
  localparam logic signed [W-1:0] X_P4  = W'(1024);
  localparam logic signed [W-1:0] X_P6  = W'(1536);

  // Per-segment derivative values (Q8.8)
  localparam logic signed [W-1:0] D_S0 = W'(0);
  localparam logic signed [W-1:0] D_S1 = W'(-5);
  localparam logic signed [W-1:0] D_S2 = W'(-25);
  localparam logic signed [W-1:0] D_S3 = W'(16);
  localparam logic signed [W-1:0] D_S4 = W'(128);
  localparam logic signed [W-1:0] D_S5 = W'(224);
  localparam logic signed [W-1:0] D_S6 = W'(280);
  localparam logic signed [W-1:0] D_S7 = W'(261);
  localparam logic signed [W-1:0] D_S8 = W'(256);

  localparam logic signed [PW-1:0] Q_MAX = PW'((2 ** (W - 1)) - 1);
  localparam logic signed [PW-1:0] Q_MIN = PW'(-(2 ** (W - 1)));

  logic                en_c;
  logic                s1_vld;
  logic signed [W-1:0] s1_x;
  logic signed [W-1:0] s1_g;
  logic                s2_vld;
  logic signed [W-1:0] s2_d;
  logic signed [W-1:0] s2_g;
  logic                out_valid_q;
  logic [W-1:0]        dx_q;
  logic                out_sat;
  logic signed [W-1:0] d_c;
  logic signed [PW-1:0] p_c;
  logic signed [PW-1:0] q_c;
  logic [W-1:0]        dx_c;
  logic                sat_c;

  // Whole pipeline moves as one unit; only a stalled valid output blocks it
  assign en_c          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready  = en_c;
  assign bus.out_valid = out_valid_q;
  assign bus.dx        = dx_q;

  // Segment decode on the S1 x
  always_comb begin
    d_c = D_S8;
    if      (s1_x < X_M6)  d_c = D_S0;
    else if (s1_x < X_M4)  d_c = D_S1;
    else if (s1_x < X_M15) d_c = D_S2;
    else if (s1_x < X_M05) d_c = D_S3;
    else if (s1_x < X_P05) d_c = D_S4;
    else if (s1_x < X_P15) d_c = D_S5;
    else if (s1_x < X_P4)  d_c = D_S6;
    else if (s1_x < X_P6)  d_c = D_S7;
  end

  // Full-precision product, floor shift, clamp to W bits
  always_comb begin
    p_c   = PW'(s2_g) * PW'(s2_d);
    q_c   = p_c >>> FRAC;
    dx_c  = q_c[W-1:0];
    sat_c = 1'b0;
    if (q_c > Q_MAX) begin
      dx_c  = {1'b0, {(W-1){1'b1}}};
      sat_c = 1'b1;
    end else if (q_c < Q_MIN) begin
      dx_c  = {1'b1, {(W-1){1'b0}}};
      sat_c = 1'b1;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld      <= 1'b0;
      s1_x        <= '0;
      s1_g        <= '0;
      s2_vld      <= 1'b0;
      s2_d        <= '0;
      s2_g        <= '0;
      out_valid_q <= 1'b0;
      dx_q        <= '0;
      out_sat     <= 1'b0;
    end else if (en_c) begin
      s1_vld      <= bus.in_valid;
      s1_x        <= bus.x;
      s1_g        <= bus.g;
      s2_vld      <= s1_vld;
      s2_d        <= d_c;
      s2_g        <= s1_g;
      out_valid_q <= s2_vld;
      // dx keeps its last value across bubbles
      if (s2_vld) begin
        dx_q    <= dx_c;
        out_sat <= sat_c;
      end
    end
  end

  // Saturation event counter, sticky at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid_q && bus.out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_silu_pwl_bwd.sv
// Randomized + directed bench for silu_pwl_bwd against a math-level reference.
module tb_silu_pwl_bwd;

  logic        clk;
  logic        rst;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  silu_pwl_bwd_if #(.W(16)) bus ();

  silu_pwl_bwd #(.W(16), .FRAC(8), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dx;
    bit          sat;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          steady = 1'b0;
  bit          acc_flag;
  bit          stall_prev = 1'b0;
  logic [15:0] hold_dx;

  logic        drv_valid = 1'b0;
  logic [15:0] drv_x = '0;
  logic [15:0] drv_g = '0;
  logic        drv_ready = 1'b1;
  logic        drv_clr = 1'b0;

  int edges[8] = '{-1536, -1024, -384, -128, 128, 384, 1024, 1536};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // dx = clamp(floor(g * silu'(x))) with silu'(x) taken from the segment table
  function automatic void ref_dx(input logic [15:0] xi, input logic [15:0] gi,
                                 output logic [15:0] dxo, output bit sat);
    real xr;
    int  gs, d, p, q;
    xr = real'(int'($signed(xi))) / 256.0;
    gs = int'($signed(gi));
    if      (xr < -6.0) d = 0;
    else if (xr < -4.0) d = -5;
    else if (xr < -1.5) d = -25;
    else if (xr < -0.5) d = 16;
    else if (xr <  0.5) d = 128;
    else if (xr <  1.5) d = 224;
    else if (xr <  4.0) d = 280;
    else if (xr <  6.0) d = 261;
    else                d = 256;
    p = gs * d;
    q = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767; sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    dxo = 16'(q);
  endfunction

  // One clock: sample outputs mid-cycle, apply drives, update the model for the next edge
  task automatic cycle();
    exp_t e;
    bit   out_xfer, xsat;
    @(negedge clk);
    check("sat_cnt", 32'(sat_cnt), 32'(exp_cnt));
    bus.in_valid  = drv_valid;
    bus.x         = drv_x;
    bus.g         = drv_g;
    bus.out_ready = drv_ready;
    sat_clr       = drv_clr;
    #1;
    if (stall_prev) begin
      check("hold_valid", 32'(bus.out_valid), 32'(1));
      check("hold_dx", 32'(bus.dx), 32'(hold_dx));
    end
    if (bus.out_valid && !drv_ready) check("stall_in_ready", 32'(bus.in_ready), 32'(0));
    out_xfer = bus.out_valid && drv_ready;
    xsat = 1'b0;
    if (out_xfer) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("dx", 32'(bus.dx), 32'(e.dx));
        if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(3));
        xsat = e.sat;
      end
    end
    if (drv_clr) exp_cnt = 0;
    else if (xsat && exp_cnt != 65535) exp_cnt++;
    acc_flag = drv_valid && bus.in_ready;
    if (acc_flag) begin
      ref_dx(drv_x, drv_g, e.dx, e.sat);
      e.cyc = cyc;
      e.lat = steady;
      sb.push_back(e);
    end
    stall_prev = bus.out_valid && !drv_ready;
    hold_dx    = bus.dx;
    cyc++;
  endtask

  task automatic send(input logic [15:0] xi, input logic [15:0] gi);
    drv_valid = 1'b1;
    drv_x     = xi;
    drv_g     = gi;
    acc_flag  = 1'b0;
    for (int i = 0; i < 20 && !acc_flag; i++) cycle();
    if (!acc_flag) check("send_timeout", 32'(0), 32'(1));
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    drv_clr   = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) cycle();
    check("drain_left", 32'(sb.size()), 32'(0));
    repeat (3) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xs[11];
    int          si;
    rst = 1'b0;
    sat_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.g = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_dx", 32'(bus.dx), 32'(0));
    check("rst_sat_cnt", 32'(sat_cnt), 32'(0));
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Basic value and latency
    steady = 1'b1;
    send(16'h0000, 16'h0100);
    drain();
    send(16'hFD00, 16'h0200);
    drain();

    // Saturation both ways, then clear
    send(16'h0200, 16'h7FFF);
    drain();
    send(16'h0200, 16'h8000);
    drain();
    check("sat_cnt_two", 32'(sat_cnt), 32'(2));
    drv_clr = 1'b1;
    cycle();
    drv_clr = 1'b0;
    cycle();

    // Segment edges
    xs = '{16'hF9FF, 16'hFA00, 16'hFBFF, 16'hFC00, 16'hFE7F, 16'hFE80,
           16'h007F, 16'h0080, 16'h05FF, 16'h0600, 16'h7FFF};
    foreach (xs[i]) send(xs[i], 16'h0100);
    send(16'h8000, 16'h0100);
    drain();

    // 8 back-to-back items with out_ready low on cycles 4..8
    steady = 1'b0;
    si = 0;
    for (int c = 0; c < 40 && si < 8; c++) begin
      drv_valid = 1'b1;
      drv_x     = 16'($urandom_range(0, 65535));
      drv_g     = 16'($urandom_range(0, 65535));
      drv_ready = !(c >= 4 && c <= 8);
      cycle();
      if (acc_flag) si++;
    end
    check("b2b_sent", 32'(si), 32'(8));
    drain();

    // Random traffic with backpressure and occasional clears
    for (int c = 0; c < 300; c++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0)
        drv_x = 16'(edges[$urandom_range(0, 7)] + int'($urandom_range(0, 4)) - 2);
      else
        drv_x = 16'($urandom_range(0, 65535));
      drv_g     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32000, 33500))
                                              : 16'($urandom_range(0, 65535));
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drv_clr = 1'b0;
    drain();

    // Mid-stream async reset with 3 items in flight
    send(16'h0200, 16'h7FFF);
    drain();
    send(16'h0010, 16'h0300);
    send(16'hFE00, 16'h0400);
    send(16'h0500, 16'hF000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'(0));
    check("arst_sat_cnt", 32'(sat_cnt), 32'(0));
    sb.delete();
    exp_cnt = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    steady = 1'b1;
    send(16'hFF00, 16'h0300);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/silu_pwl_bwd.md
Name: silu_pwl_bwd

Overview:
- Backward-pass companion to the forward PWL SiLU activation unit.
- Takes the saved forward input x and the upstream gradient g. Produces dx = g * silu'(x), where silu'(x) is a piecewise-constant approximation.
- Sits in the training datapath, after the gradient stream from the next layer and before the weight-gradient accumulator.
- Streaming, fully pipelined, 3-cycle latency, valid/ready on both sides.

Parameters:
- W, 16, data width of x, g and dx (Q8.8 signed two's complement).
- FRAC, 8, fractional bits; the product is shifted right by FRAC.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  x/g pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- x  in  W  forward-pass input, Q8.8 signed.
- g  in  W  upstream gradient, Q8.8 signed.
- out_valid  out  1  dx valid.
- out_ready  in  1  downstream accepts dx.
- dx  out  W  g * silu'(x), Q8.8 signed, saturated.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  count of saturated outputs; sticks at all-ones.

Behaviour:
- Reset (rst low, asynchronous): all stage valids = 0, out_valid = 0, dx = 0, sat_cnt = 0. Any in-flight data is discarded. in_ready = 1 in the first cycle after release.
- Pipeline enable: en = out_ready | ~out_valid. in_ready = en. All three stages advance together only when en = 1; otherwise every stage register holds.
- A transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Latency is exactly 3 enabled cycles from input transfer to out_valid. Order is preserved. No bubbles are inserted when the stream is back-to-back.
- S1: register x, g and valid.
- S2: segment decode on the registered x, using signed compares, lower bound inclusive. Register d and g.
  - x < 0xFA00 (-6.0): d = 0x0000
  - [-6.0, 0xFC00 (-4.0)): d = 0xFFFB (-5)
  - [-4.0, 0xFE80 (-1.5)): d = 0xFFE7 (-25)
  - [-1.5, 0xFF80 (-0.5)): d = 0x0010
  - [-0.5, 0x0080 (0.5)): d = 0x0080
  - [0.5, 0x0180 (1.5)): d = 0x00E0
  - [1.5, 0x0400 (4.0)): d = 0x0118
  - [4.0, 0x0600 (6.0)): d = 0x0105
  - x >= 6.0: d = 0x0100
- S3: p = g * d as a 2W-bit signed product. q = p >>> FRAC (arithmetic shift, truncation toward -inf).
  - If q > 0x7FFF: dx = 0x7FFF. If q < -0x8000: dx = 0x8000. Either case is flagged as saturated. Otherwise dx = q[W-1:0].
  - dx and out_valid are registered outputs.
  - While out_valid = 0, dx holds its last value (0 after reset). Checkers must not sample it then.
- sat_cnt increments by 1 on each output transfer whose dx was saturated. It saturates at 2^CNT_W-1.
- sat_clr = 1 clears sat_cnt to 0 at the clock edge; clear has priority over a simultaneous increment.
- Backpressure: while out_valid = 1 and out_ready = 0, dx, out_valid and all stages are frozen and in_ready = 0. No data is lost or duplicated.
- Reset asserted mid-stream: outputs clear immediately, without waiting for a clock edge. Stream restarts clean after release.

Test Plan:
- x=0x0000, g=0x0100, out_ready=1 -> dx=0x0080, out_valid high exactly 3 cycles after the input transfer.
- x=0xFD00 (-3.0), g=0x0200 -> d=-25, p=-0x3200, dx=0xFFCE, sat_cnt unchanged.
- x=0x0200, g=0x7FFF -> dx=0x7FFF, sat_cnt=1. Then x=0x0200, g=0x8000 -> dx=0x8000, sat_cnt=2. Then sat_clr pulse -> sat_cnt=0.
- Segment edges, g=0x0100:
  - x=0xF9FF -> dx=0x0000; x=0xFA00 -> dx=0xFFFB.
  - x=0x007F -> 0x0080; x=0x0080 -> 0x00E0.
  - x=0x05FF -> 0x0105; x=0x0600 -> 0x0100.
  - x=0x7FFF -> 0x0100.
- Stream 8 back-to-back pairs with out_ready held low for cycles 4-8 -> in_ready low while stalled, outputs held stable, all 8 results emitted in order with no loss or duplicate.
- Assert rst mid-stream with 3 items in flight -> out_valid=0, sat_cnt=0 asynchronously. After release, the next input yields a correct dx 3 cycles later and no stale item appears.
